wb_write_port: RTL and testbench

Writeback side of the 16x16 register file. It accepts destination-register results from two producers: the ALU path and the memory-load path. Results are queued in a small in-order FIFO and drained one per cycle into the register file's single write port (we/Rd/writeData). It also gives a forwarding lookup over pending writes, and a halt/drain handshake so the register dump runs only after all writes have landed.

---
 rtl/wb_write_port.sv | 91 +++++++++
 tb/tb_wb_write_port.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wb_write_port.sv
// wb_write_port: in-order writeback FIFO feeding the register file's single write port.
//   ALU/load producers : *_valid/*_ready/*_rd/*_data; the load wins when only one slot is free
//   register file port : rf_we/rf_rd/rf_wdata, driven straight from the FIFO head entry
//   forwarding         : q_reg -> q_hit/q_data, youngest pending write to q_reg
//   halt/drain         : hlt (sticky once seen), drained once halted and empty; wr_count counts writes
module wb_write_port #(
  parameter int DEPTH = 4,
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] q_reg,
  output logic          q_hit,
  output logic [DW-1:0] q_data,
  input  logic          hlt,
  output logic          drained,
  output logic [15:0]   wr_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [AW-1:0] rd_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail, alu_slot, idx;
  logic [PW:0] count, free;
  logic halting, mem_enq, alu_enq, pop;
  assign free = FULL - count;
  assign mem_ready = !halting && |free;
  assign alu_ready = !halting && (|free[PW:1] || (|free && !mem_valid));
  // rd==0 transfers handshake normally but never occupy a slot
  assign mem_enq = mem_valid && mem_ready && |mem_rd;
  assign alu_enq = alu_valid && alu_ready && |alu_rd;
  assign alu_slot = tail + PW'(mem_enq);
  assign pop = |count;
  assign rf_we = pop;
  assign rf_rd = rd_q[head];
  assign rf_wdata = data_q[head];
  // walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    q_hit = 1'b0;
    q_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((PW+1)'(i) < count && rd_q[idx] == q_reg && |q_reg) begin
        q_hit = 1'b1;
        q_data = data_q[idx];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
        data_q[i] <= '0;
      end
      head <= '0;
      tail <= '0;
      count <= '0;
      halting <= 1'b0;
      drained <= 1'b0;
      wr_count <= '0;
    end else begin
      if (mem_enq) begin
        rd_q[tail] <= mem_rd;
        data_q[tail] <= mem_data;
      end
      if (alu_enq) begin
        rd_q[alu_slot] <= alu_rd;
        data_q[alu_slot] <= alu_data;
      end
      tail <= alu_slot + PW'(alu_enq);
      head <= head + PW'(pop);
      count <= count + (PW+1)'(mem_enq) + (PW+1)'(alu_enq) - (PW+1)'(pop);
      halting <= halting | hlt;
      drained <= halting && count == '0;
      wr_count <= wr_count + 16'(pop);
    end
  end
endmodule

// File: tb/tb_wb_write_port.sv
// tb_wb_write_port: directed vector table plus flood and mid-run reset sequences for wb_write_port.
module tb_wb_write_port;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid, alu_ready, mem_valid, mem_ready, rf_we, q_hit, hlt, drained;
  logic [3:0] alu_rd, mem_rd, rf_rd, q_reg;
  logic [15:0] alu_data, mem_data, rf_wdata, q_data, wr_count;
  int checks = 0, failures = 0;

  wb_write_port #(.DEPTH(4), .DW(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .q_reg(q_reg), .q_hit(q_hit), .q_data(q_data),
    .hlt(hlt), .drained(drained), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [3:0] ard; logic [15:0] ad;
    logic mv; logic [3:0] mrd; logic [15:0] md;
    logic [3:0] q; logic h;
    logic ear, emr, ewe; logic [3:0] erd; logic [15:0] ewd;
    logic eqh; logic [15:0] eqd; logic edr; logic [15:0] ewc;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] sb [$];
    int cnt, acc, wrs, efree;
    logic ear, emr;
    vecs[0]  = '{1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0};
    vecs[1]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0, 1, 1, 1, 3, 16'h1234, 1, 16'h1234, 0, 0};
    vecs[2]  = '{1, 6, 16'h5555, 1, 5, 16'hAAAA, 3, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1};
    vecs[3]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 5, 0, 1, 1, 1, 5, 16'hAAAA, 1, 16'hAAAA, 0, 1};
    vecs[4]  = '{1, 7, 16'h0002, 1, 7, 16'h0001, 6, 0, 1, 1, 1, 6, 16'h5555, 1, 16'h5555, 0, 2};
    vecs[5]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 7, 0, 1, 1, 1, 7, 16'h0001, 1, 16'h0002, 0, 3};
    vecs[6]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 7, 16'h0002, 0, 16'h0000, 0, 4};
    vecs[7]  = '{1, 0, 16'hFFFF, 0, 0, 16'h0000, 7, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 5};
    vecs[8]  = '{1, 1, 16'h0011, 1, 2, 16'h0022, 1, 0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 5};
    vecs[9]  = '{1, 3, 16'h0033, 0, 0, 16'h0000, 1, 1, 1, 1, 1, 2, 16'h0022, 1, 16'h0011, 0, 5};
    vecs[10] = '{1, 4, 16'h0044, 1, 8, 16'h0088, 0, 1, 0, 0, 1, 1, 16'h0011, 0, 16'h0000, 0, 6};
    vecs[11] = '{1, 4, 16'h0044, 1, 8, 16'h0088, 0, 0, 0, 0, 1, 3, 16'h0033, 0, 16'h0000, 0, 7};
    vecs[12] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 8};
    vecs[13] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 8};
    idle(); hlt = 0; q_reg = 0;
    #12;
    chk("reset rf_we", rf_we, 0);
    chk("reset rf_rd", rf_rd, 0);
    chk("reset rf_wdata", rf_wdata, 0);
    chk("reset q_hit", q_hit, 0);
    chk("reset q_data", q_data, 0);
    chk("reset drained", drained, 0);
    chk("reset wr_count", wr_count, 0);
    @(negedge clk) rst_n = 1;
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      alu_valid = vecs[r].av; alu_rd = vecs[r].ard; alu_data = vecs[r].ad;
      mem_valid = vecs[r].mv; mem_rd = vecs[r].mrd; mem_data = vecs[r].md;
      q_reg = vecs[r].q; hlt = vecs[r].h;
      #1;
      chk($sformatf("v%0d alu_ready", r), alu_ready, vecs[r].ear);
      chk($sformatf("v%0d mem_ready", r), mem_ready, vecs[r].emr);
      chk($sformatf("v%0d rf_we", r), rf_we, vecs[r].ewe);
      if (vecs[r].ewe) begin
        chk($sformatf("v%0d rf_rd", r), rf_rd, vecs[r].erd);
        chk($sformatf("v%0d rf_wdata", r), rf_wdata, vecs[r].ewd);
      end
      chk($sformatf("v%0d q_hit", r), q_hit, vecs[r].eqh);
      chk($sformatf("v%0d q_data", r), q_data, vecs[r].eqd);
      chk($sformatf("v%0d drained", r), drained, vecs[r].edr);
      chk($sformatf("v%0d wr_count", r), wr_count, vecs[r].ewc);
    end
    @(negedge clk);
    idle(); hlt = 0; q_reg = 0;
    rst_n = 0;
    #1 rst_n = 1;
    cnt = 0; acc = 0; wrs = 0;
    for (int c = 0; c < 200 && (acc < 20 || cnt > 0); c++) begin
      @(negedge clk);
      mem_valid = acc < 20; mem_rd = 4'((acc % 15) + 1); mem_data = 16'hB000 + 16'(acc);
      alu_valid = acc + 1 < 20; alu_rd = 4'(((acc + 1) % 15) + 1); alu_data = 16'hB000 + 16'(acc + 1);
      #1;
      efree = 4 - cnt;
      emr = efree >= 1;
      ear = efree >= 2 || (efree >= 1 && !mem_valid);
      chk($sformatf("flood c%0d mem_ready", c), mem_ready, emr);
      chk($sformatf("flood c%0d alu_ready", c), alu_ready, ear);
      chk($sformatf("flood c%0d rf_we", c), rf_we, cnt != 0);
      if (cnt != 0 && sb.size() > 0) begin
        chk($sformatf("flood c%0d write", c), {rf_rd, rf_wdata}, sb[0]);
        void'(sb.pop_front());
        wrs++;
      end
      if (cnt != 0) cnt--;
      if (mem_valid && emr) begin sb.push_back({mem_rd, mem_data}); acc++; cnt++; end
      if (alu_valid && ear) begin sb.push_back({alu_rd, alu_data}); acc++; cnt++; end
    end
    chk("flood writes", wrs, 20);
    chk("flood leftover", sb.size(), 0);
    @(negedge clk);
    mem_valid = 1; mem_rd = 9; mem_data = 16'h0909;
    alu_valid = 1; alu_rd = 10; alu_data = 16'h0A0A;
    @(negedge clk);
    mem_rd = 11; mem_data = 16'h0B0B; alu_rd = 12; alu_data = 16'h0C0C;
    @(negedge clk);
    idle(); q_reg = 11;
    #1;
    chk("pre-reset rf_we", rf_we, 1);
    chk("pre-reset q_hit", q_hit, 1);
    #2 rst_n = 0;
    #1;
    chk("mid-reset rf_we", rf_we, 0);
    chk("mid-reset wr_count", wr_count, 0);
    chk("mid-reset drained", drained, 0);
    chk("mid-reset q_hit", q_hit, 0);
    #1 rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-reset c%0d rf_we", k), rf_we, 0);
      chk($sformatf("post-reset c%0d wr_count", k), wr_count, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
